cache_2way_param: RTL and testbench



---
 rtl/cache_2way_param.sv | 195 +++++++++++++++++++
 tb/tb_cache_2way_param.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_2way_param.sv
// Two-way set-associative byte cache with LRU replacement, beat-by-beat line fill
// and a set-at-a-time flush. One request is in flight at a time.
module cache_2way_param #(
  parameter int ADDR_W   = 16,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [DATA_W-1:0] resp_data,
  output logic              busy
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int BYTES = 1 << OFFSET_W;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE, so nothing is taken while busy.
  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FILL, S_FLUSH} state_e;

  state_e state_q, state_d;

  logic [1:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic [INDEX_W-1:0]  idx_q;
  logic [OFFSET_W-1:0] off_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                victim_q;
  logic [OFFSET_W-1:0] fill_cnt_q;
  logic [INDEX_W-1:0]  flush_cnt_q;
  logic [1:0][SETS-1:0] valid_q;
  logic [SETS-1:0]     lru_q;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;

  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [DATA_W-1:0] data_mem [2][SETS][BYTES];

  logic [TAG_W-1:0]    in_tag;
  logic [INDEX_W-1:0]  in_idx;
  logic [OFFSET_W-1:0] in_off;
  assign {in_tag, in_idx, in_off} = req_addr;

  logic accept;
  assign accept = req_valid && (state_q == S_IDLE);

  // Lookup against the registered request
  logic lk_hit0, lk_hit1, lk_hit, lk_way;
  logic [DATA_W-1:0] lk_byte;
  assign lk_hit0 = valid_q[0][idx_q] && (tag_mem[0][idx_q] == tag_q);
  assign lk_hit1 = valid_q[1][idx_q] && (tag_mem[1][idx_q] == tag_q);
  assign lk_hit  = lk_hit0 || lk_hit1;
  assign lk_way  = !lk_hit0;
  assign lk_byte = data_mem[lk_way][idx_q][off_q];

  // Victim choice at fill entry uses the incoming address so the line is claimed on acceptance
  logic en_hit0, en_hit1, victim_sel;
  assign en_hit0 = valid_q[0][in_idx] && (tag_mem[0][in_idx] == in_tag);
  assign en_hit1 = valid_q[1][in_idx] && (tag_mem[1][in_idx] == in_tag);

  always_comb begin
    victim_sel = lru_q[in_idx];
    if (en_hit0)                victim_sel = 1'b0;
    else if (en_hit1)           victim_sel = 1'b1;
    else if (!valid_q[0][in_idx]) victim_sel = 1'b0;
    else if (!valid_q[1][in_idx]) victim_sel = 1'b1;
  end

  logic last_beat, last_set;
  assign last_beat = (state_q == S_FILL) && fill_valid && (&fill_cnt_q);
  assign last_set  = (state_q == S_FLUSH) && (&flush_cnt_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_FILL:  state_d = S_FILL;
            OP_FLUSH: state_d = S_FLUSH;
            default:  state_d = S_LOOKUP;
          endcase
        end
      end
      S_LOOKUP: state_d = S_IDLE;
      S_FILL:   if (last_beat) state_d = S_IDLE;
      S_FLUSH:  if (last_set)  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    resp_data_d  = '0;
    if (state_q == S_LOOKUP) begin
      resp_valid_d = 1'b1;
      resp_hit_d   = lk_hit;
      if (lk_hit && (op_q == OP_READ)) resp_data_d = lk_byte;
    end else if (last_beat || last_set) begin
      resp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q         <= OP_READ;
      tag_q        <= '0;
      idx_q        <= '0;
      off_q        <= '0;
      wdata_q      <= '0;
      victim_q     <= 1'b0;
      fill_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      valid_q      <= '0;
      lru_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_data_q  <= resp_data_d;
      if (accept) begin
        op_q    <= req_op;
        tag_q   <= in_tag;
        idx_q   <= in_idx;
        off_q   <= in_off;
        wdata_q <= req_wdata;
        if (req_op == OP_FILL) begin
          victim_q                   <= victim_sel;
          valid_q[victim_sel][in_idx] <= 1'b0;
          fill_cnt_q                 <= '0;
        end
        if (req_op == OP_FLUSH) flush_cnt_q <= '0;
      end
      if ((state_q == S_LOOKUP) && lk_hit) lru_q[idx_q] <= ~lk_way;
      if ((state_q == S_FILL) && fill_valid) begin
        fill_cnt_q <= fill_cnt_q + OFFSET_W'(1);
        if (&fill_cnt_q) begin
          valid_q[victim_q][idx_q] <= 1'b1;
          lru_q[idx_q]             <= ~victim_q;
        end
      end
      if (state_q == S_FLUSH) begin
        valid_q[0][flush_cnt_q] <= 1'b0;
        valid_q[1][flush_cnt_q] <= 1'b0;
        lru_q[flush_cnt_q]      <= 1'b0;
        flush_cnt_q             <= flush_cnt_q + INDEX_W'(1);
      end
    end
  end

  // Arrays hold no reset; the valid bits alone decide what is resident
  always_ff @(posedge clk) begin
    if ((state_q == S_FILL) && fill_valid) begin
      data_mem[victim_q][idx_q][fill_cnt_q] <= fill_data;
      if (&fill_cnt_q) tag_mem[victim_q][idx_q] <= tag_q;
    end
    if ((state_q == S_LOOKUP) && lk_hit && (op_q == OP_STORE))
      data_mem[lk_way][idx_q][off_q] <= wdata_q;
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_cache_2way_param.sv
// Directed bench for cache_2way_param: hit/miss, LRU eviction, store, refill,
// flush timing and reset abort, with hand-computed expected values.
module tb_cache_2way_param;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        fill_valid = 1'b0;
  logic [7:0]  fill_data = '0;
  logic        resp_valid;
  logic        resp_hit;
  logic [7:0]  resp_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  cache_2way_param dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_data(resp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called #1 after the acceptance edge; returns the response and its edge count
  task automatic wait_resp(output logic h, output logic [7:0] d, output int lat);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) chk("resp_timeout", 32'd0, 32'd1);
    h = resp_hit;
    d = resp_data;
  endtask

  task automatic do_read(input string tag, input logic [15:0] addr,
                         input logic exp_hit, input logic [7:0] exp_data);
    logic h;
    logic [7:0] d;
    int lat;
    issue(OP_READ, addr, 8'h00);
    wait_resp(h, d, lat);
    chk({tag, "_hit"}, {31'd0, h}, {31'd0, exp_hit});
    chk({tag, "_data"}, {24'd0, d}, {24'd0, exp_data});
  endtask

  task automatic do_store(input string tag, input logic [15:0] addr,
                          input logic [7:0] wd, input logic exp_hit);
    logic h;
    logic [7:0] d;
    int lat;
    issue(OP_STORE, addr, wd);
    wait_resp(h, d, lat);
    chk({tag, "_hit"}, {31'd0, h}, {31'd0, exp_hit});
    chk({tag, "_data"}, {24'd0, d}, 32'd0);
  endtask

  task automatic do_fill(input string tag, input logic [15:0] addr,
                         input logic [31:0] beats, input bit gap);
    issue(OP_FILL, addr, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      fill_valid = 1'b1;
      fill_data  = beats[31-8*k -: 8];
      @(posedge clk);
      #1;
      fill_valid = 1'b0;
      if (gap && k == 1) begin
        @(posedge clk);
        #1;
      end
    end
    chk({tag, "_resp"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_hit"}, {31'd0, resp_hit}, 32'd0);
  endtask

  initial begin
    logic h;
    logic [7:0] d;
    int lat;
    int n;

    // Reset values, checked before any clock edge
    #2;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", {24'd0, resp_data}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Cold read: one pulse on the second edge after acceptance
    issue(OP_READ, 16'h1234, 8'h00);
    chk("cold_early", {31'd0, resp_valid}, 32'd0);
    chk("cold_busy", {31'd0, busy}, 32'd1);
    wait_resp(h, d, lat);
    chk("cold_lat", lat, 32'd1);
    chk("cold_hit", {31'd0, h}, 32'd0);
    chk("cold_data", {24'd0, d}, 32'd0);
    @(posedge clk);
    #1;
    chk("cold_pulse_end", {31'd0, resp_valid}, 32'd0);

    // Fill with a stall cycle, then read offset 2
    do_fill("fill1234", 16'h1234, 32'hAABBCCDD, 1'b1);
    do_read("rd1236", 16'h1236, 1'b1, 8'hCC);
    do_read("rd1234", 16'h1234, 1'b1, 8'hAA);

    // Index 5: tags 0x001 (0x0054), 0x002 (0x0094), 0x003 (0x00D4)
    do_fill("fill_t1", 16'h0054, 32'h01020304, 1'b0);
    do_fill("fill_t2", 16'h0094, 32'h05060708, 1'b0);
    do_read("rd_t1a", 16'h0055, 1'b1, 8'h02);
    do_fill("fill_t3", 16'h00D4, 32'h090A0B0C, 1'b0);
    do_read("rd_t2_evicted", 16'h0094, 1'b0, 8'h00);
    do_read("rd_t1_kept", 16'h0057, 1'b1, 8'h04);
    do_read("rd_t3", 16'h00D6, 1'b1, 8'h0B);

    // Stores: hit writes in place, miss does not allocate
    do_store("st1235", 16'h1235, 8'h55, 1'b1);
    do_read("rd1235", 16'h1235, 1'b1, 8'h55);
    do_store("st9998", 16'h9998, 8'h77, 1'b0);
    do_read("rd9998", 16'h9998, 1'b0, 8'h00);

    // Refill of a resident line reuses its way; a second tag then takes the other way
    do_fill("refill1234", 16'h1234, 32'h11223344, 1'b0);
    do_read("rd_refill0", 16'h1234, 1'b1, 8'h11);
    do_read("rd_refill3", 16'h1237, 1'b1, 8'h44);
    do_fill("fill1274", 16'h1274, 32'hE0E1E2E3, 1'b0);
    do_read("rd_refill_again", 16'h1235, 1'b1, 8'h22);
    do_read("rd1274", 16'h1276, 1'b1, 8'hE2);

    // Flush: 16 busy cycles, then a miss-flavoured response
    issue(OP_FLUSH, 16'h0000, 8'h00);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("flush_busy_cycles", n, 32'd16);
    chk("flush_resp", {31'd0, resp_valid}, 32'd1);
    chk("flush_hit", {31'd0, resp_hit}, 32'd0);
    do_read("post_flush_1234", 16'h1234, 1'b0, 8'h00);
    do_read("post_flush_t1", 16'h0054, 1'b0, 8'h00);
    do_read("post_flush_t3", 16'h00D4, 1'b0, 8'h00);

    // Make the line resident again, then abort a refill with reset on its third beat
    do_fill("fill_pre_abort", 16'h1234, 32'h61626364, 1'b0);
    do_read("rd_pre_abort", 16'h1236, 1'b1, 8'h63);
    issue(OP_FILL, 16'h1234, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      fill_valid = 1'b1;
      fill_data  = 8'hA0 + 8'(k);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    fill_data = 8'hA2;
    #2;
    reset = 1'b0;
    #1;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_resp", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    fill_valid = 1'b0;
    reset = 1'b1;
    do_read("abort_1234", 16'h1234, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
